rr_pkt_arbiter: RTL and testbench



---
 rtl/rr_pkt_arbiter_if.sv | 30 +++
 rtl/rr_pkt_arbiter.sv | 165 ++++++++++++++++
 tb/tb_rr_pkt_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_pkt_arbiter_if.sv
// Stream bundle between NumIn packet sources, the round-robin packet arbiter and one shared sink.
// The slave modport is the arbiter's view of the bundle, and the master modport is the sources' and sink's view.
`timescale 1ns/1ps
interface rr_pkt_arbiter_if #(
    parameter int NumIn     = 4,
    parameter int DataWidth = 32
);
    localparam int IdxWidth = $clog2(NumIn);

    logic [NumIn-1:0]                valid_i;
    logic [NumIn-1:0]                ready_o;
    logic [NumIn-1:0][DataWidth-1:0] data_i;
    logic [NumIn-1:0]                last_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [DataWidth-1:0]            data_o;
    logic                            last_o;
    logic [IdxWidth-1:0]             idx_o;
    logic                            locked_o;

    modport slave (
        input  valid_i, data_i, last_i, ready_i,
        output ready_o, valid_o, data_o, last_o, idx_o, locked_o
    );

    modport master (
        output valid_i, data_i, last_i, ready_i,
        input  ready_o, valid_o, data_o, last_o, idx_o, locked_o
    );
endinterface

// File: rtl/rr_pkt_arbiter.sv
// Packet-aware round-robin arbiter: once a packet wins, the grant stays locked until the last beat; PktQuantum packets per turn.
// Optional stall timeout on a locked source when RR_PKT_ARB_TIMEOUT_EN is defined (adds TimeoutCycles and timeout_o).
`timescale 1ns/1ps
module rr_pkt_arbiter #(
    parameter int NumIn      = 4,
    parameter int DataWidth  = 32,
    parameter int PktQuantum = 1,
    parameter int IdxWidth   = $clog2(NumIn)
`ifdef RR_PKT_ARB_TIMEOUT_EN
    ,
    parameter int TimeoutCycles = 64
`endif
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    rr_pkt_arbiter_if.slave    bus
`ifdef RR_PKT_ARB_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);
    localparam int CntWidth = $clog2(PktQuantum + 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state_reg;
    logic [IdxWidth-1:0]   rr_reg;
    logic [IdxWidth-1:0]   lock_reg;
    logic [IdxWidth-1:0]   prev_reg;
    logic [CntWidth-1:0]   q_cnt_reg;
    logic                  locked_reg;

    logic [IdxWidth-1:0]   sel_idle;
    logic [IdxWidth-1:0]   cand;
    logic                  found;
    logic [IdxWidth-1:0]   sel;
    logic                  sel_valid;
    logic                  fire;
    int                    pkt_n;
    logic [IdxWidth-1:0]   rr_end;
    logic [CntWidth-1:0]   q_end;

    // Scan upward from the slot just above the pointer, wrapping modulo NumIn.
    always_comb begin
        sel_idle = rr_reg;
        found    = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NumIn; i++) begin
            cand = IdxWidth'((int'(rr_reg) + i) % NumIn);
            if (!found && bus.valid_i[cand]) begin
                sel_idle = cand;
                found    = 1'b1;
            end
        end
    end

    assign sel       = (state_reg == LOCKED) ? lock_reg : sel_idle;
    assign sel_valid = bus.valid_i[sel] && !flush_i;
    assign fire      = sel_valid && bus.ready_i;

    assign bus.valid_o  = sel_valid;
    assign bus.data_o   = bus.data_i[sel];
    assign bus.last_o   = bus.last_i[sel];
    assign bus.idx_o    = sel;
    assign bus.locked_o = locked_reg;

    generate
        for (genvar gi = 0; gi < NumIn; gi++) begin : g_ready
            assign bus.ready_o[gi] = fire && (sel == IdxWidth'(gi));
        end
    endgenerate

    // A winner that has not used up its quantum keeps top priority by parking the pointer just below it.
    always_comb begin
        pkt_n = (sel == prev_reg) ? int'(q_cnt_reg) + 1 : 1;
        if (pkt_n < PktQuantum) begin
            rr_end = (sel == '0) ? IdxWidth'(NumIn - 1) : sel - IdxWidth'(1);
            q_end  = CntWidth'(pkt_n);
        end else begin
            rr_end = sel;
            q_end  = '0;
        end
    end

`ifdef RR_PKT_ARB_TIMEOUT_EN
    localparam int ToWidth = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
    logic [ToWidth-1:0] to_cnt_reg;
    logic               timeout_reg;
    assign timeout_o = timeout_reg;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            rr_reg     <= IdxWidth'(NumIn - 1);
            lock_reg   <= '0;
            prev_reg   <= '0;
            q_cnt_reg  <= '0;
            locked_reg <= 1'b0;
`ifdef RR_PKT_ARB_TIMEOUT_EN
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
`endif
        end else if (flush_i) begin
            state_reg  <= IDLE;
            rr_reg     <= IdxWidth'(NumIn - 1);
            lock_reg   <= '0;
            prev_reg   <= '0;
            q_cnt_reg  <= '0;
            locked_reg <= 1'b0;
`ifdef RR_PKT_ARB_TIMEOUT_EN
            to_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
`ifdef RR_PKT_ARB_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        if (bus.last_i[sel]) begin
                            rr_reg    <= rr_end;
                            q_cnt_reg <= q_end;
                            prev_reg  <= sel;
                        end else begin
                            state_reg  <= LOCKED;
                            locked_reg <= 1'b1;
                            lock_reg   <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (fire && bus.last_i[sel]) begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                        rr_reg     <= rr_end;
                        q_cnt_reg  <= q_end;
                        prev_reg   <= sel;
                    end
`ifdef RR_PKT_ARB_TIMEOUT_EN
                    if (bus.valid_i[lock_reg]) begin
                        to_cnt_reg <= '0;
                    end else if (to_cnt_reg == ToWidth'(TimeoutCycles - 1)) begin
                        // Give up on a stalled packet and hand priority to the next source.
                        state_reg   <= IDLE;
                        locked_reg  <= 1'b0;
                        rr_reg      <= lock_reg;
                        q_cnt_reg   <= '0;
                        to_cnt_reg  <= '0;
                        timeout_reg <= 1'b1;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + ToWidth'(1);
                    end
`endif
                end
                default: begin
                    state_reg  <= IDLE;
                    locked_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Bench for rr_pkt_arbiter: directed vector tables on a quantum-1 and a quantum-2 instance, then random packet traffic
// checked against a run-length/priority model of the arbitration rules.
`timescale 1ns/1ps
module tb_rr_pkt_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush0 = 1'b0;
    logic flush1 = 1'b0;
    always #5 clk = ~clk;

    rr_pkt_arbiter_if #(.NumIn(N), .DataWidth(DW)) bus0 ();
    rr_pkt_arbiter_if #(.NumIn(N), .DataWidth(DW)) bus1 ();

`ifdef RR_PKT_ARB_TIMEOUT_EN
    logic timeout0;
    logic timeout1;
    rr_pkt_arbiter #(.NumIn(N), .DataWidth(DW), .PktQuantum(1), .TimeoutCycles(4)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .bus(bus0), .timeout_o(timeout0));
    rr_pkt_arbiter #(.NumIn(N), .DataWidth(DW), .PktQuantum(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .bus(bus1), .timeout_o(timeout1));
`else
    rr_pkt_arbiter #(.NumIn(N), .DataWidth(DW), .PktQuantum(1)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush0), .bus(bus0));
    rr_pkt_arbiter #(.NumIn(N), .DataWidth(DW), .PktQuantum(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .bus(bus1));
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0] v;
        logic [3:0] l;
        logic       rdy;
        logic       fl;
        logic       ev;
        logic [3:0] er;
        int         ei;
        logic       el;
    } vec_t;

    vec_t tbl0[$];
    vec_t tbl1[$];
    logic [N-1:0][DW-1:0] fixed_dat;

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic rdy, input logic fl,
                                input logic ev, input logic [3:0] er, input int ei, input logic el);
        vec_t r;
        r.v = v; r.l = l; r.rdy = rdy; r.fl = fl; r.ev = ev; r.er = er; r.ei = ei; r.el = el;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic [3:0] v, input logic [3:0] l, input logic rdy, input logic fl,
                         input logic [N-1:0][DW-1:0] dat);
        if (d == 0) begin
            bus0.valid_i = v; bus0.last_i = l; bus0.ready_i = rdy; bus0.data_i = dat; flush0 = fl;
        end else begin
            bus1.valid_i = v; bus1.last_i = l; bus1.ready_i = rdy; bus1.data_i = dat; flush1 = fl;
        end
    endtask

    task automatic check_outputs(input int d, input string tag, input logic ev, input logic [3:0] er, input int ei,
                                 input logic el, input logic [N-1:0][DW-1:0] dat, input logic [3:0] l);
        logic          vo, lo, lk;
        logic [3:0]    ro;
        logic [DW-1:0] dout;
        logic [1:0]    io;
        if (d == 0) begin
            vo = bus0.valid_o; ro = bus0.ready_o; dout = bus0.data_o; lo = bus0.last_o; io = bus0.idx_o; lk = bus0.locked_o;
        end else begin
            vo = bus1.valid_o; ro = bus1.ready_o; dout = bus1.data_o; lo = bus1.last_o; io = bus1.idx_o; lk = bus1.locked_o;
        end
        chk({tag, " valid_o"}, 64'(vo), 64'(ev));
        chk({tag, " ready_o"}, 64'(ro), 64'(er));
        chk({tag, " locked_o"}, 64'(lk), 64'(el));
        if (ev) begin
            chk({tag, " idx_o"}, 64'(io), 64'(ei));
            chk({tag, " data_o"}, 64'(dout), 64'(dat[ei]));
            chk({tag, " last_o"}, 64'(lo), 64'(l[ei]));
        end
    endtask

    task automatic run_table(input int d, input string name, input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            drive(d, t[i].v, t[i].l, t[i].rdy, t[i].fl, fixed_dat);
            @(negedge clk);
            check_outputs(d, $sformatf("%s[%0d]", name, i), t[i].ev, t[i].er, t[i].ei, t[i].el, fixed_dat, t[i].l);
            $display("%s[%0d] dut%0d valid=%b last=%b ready_i=%b flush=%b exp_idx=%0d exp_ready=%b",
                     name, i, d, t[i].v, t[i].l, t[i].rdy, t[i].fl, t[i].ei, t[i].er);
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: current lock plus the source holding top priority; the quantum is tracked as the
    // length of the current run of consecutive packet wins by one source.
    int m_locked[2];
    int m_lock[2];
    int m_top[2];
    int m_who[2];
    int m_run[2];
    int qv[2] = '{1, 2};

    task automatic model_reset(input int d);
        m_locked[d] = 0; m_lock[d] = 0; m_top[d] = 0; m_who[d] = -1; m_run[d] = 0;
    endtask

    task automatic model_pkt_end(input int d, input int k);
        int n;
        if (m_who[d] == k) m_run[d]++;
        else begin
            m_who[d] = k;
            m_run[d] = 1;
        end
        n = ((m_run[d] - 1) % qv[d]) + 1;
        m_top[d] = (n < qv[d]) ? k : (k + 1) % N;
    endtask

    int rem[2][N];
    logic [DW-1:0] sdat[2][N];
    logic [3:0] rv[2], rl[2], rer[2];
    logic rrdy[2], rfl[2], rev[2];
    int rei[2];
    logic [N-1:0][DW-1:0] rdat[2];

    initial begin
        for (int k = 0; k < N; k++) fixed_dat[k] = 32'hA0 + DW'(k);

        // Single-beat round robin, then a 3-beat lock, a mid-packet sink stall, a mid-packet flush, idle corners.
        tbl0.push_back(mk(4'hf, 4'hf, 1, 0, 1, 4'b0001, 0, 0));
        tbl0.push_back(mk(4'hf, 4'hf, 1, 0, 1, 4'b0010, 1, 0));
        tbl0.push_back(mk(4'hf, 4'hf, 1, 0, 1, 4'b0100, 2, 0));
        tbl0.push_back(mk(4'hf, 4'hf, 1, 0, 1, 4'b1000, 3, 0));
        tbl0.push_back(mk(4'hf, 4'hf, 1, 0, 1, 4'b0001, 0, 0));
        tbl0.push_back(mk(4'hf, 4'hf, 1, 1, 0, 4'b0000, 0, 0));
        tbl0.push_back(mk(4'b0110, 4'b0000, 1, 0, 1, 4'b0010, 1, 0));
        tbl0.push_back(mk(4'b0110, 4'b0000, 1, 0, 1, 4'b0010, 1, 1));
        tbl0.push_back(mk(4'b0110, 4'b0010, 1, 0, 1, 4'b0010, 1, 1));
        tbl0.push_back(mk(4'b0100, 4'b0100, 1, 0, 1, 4'b0100, 2, 0));
        tbl0.push_back(mk(4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 0, 0));
        tbl0.push_back(mk(4'b0101, 4'b0000, 1, 0, 1, 4'b0001, 0, 0));
        for (int i = 0; i < 5; i++) tbl0.push_back(mk(4'b0101, 4'b0000, 0, 0, 1, 4'b0000, 0, 1));
        tbl0.push_back(mk(4'b0101, 4'b0001, 1, 0, 1, 4'b0001, 0, 1));
        tbl0.push_back(mk(4'b0100, 4'b0100, 1, 0, 1, 4'b0100, 2, 0));
        tbl0.push_back(mk(4'b0000, 4'b0000, 1, 1, 0, 4'b0000, 0, 0));
        tbl0.push_back(mk(4'b1000, 4'b0000, 1, 0, 1, 4'b1000, 3, 0));
        tbl0.push_back(mk(4'b1000, 4'b0000, 1, 0, 1, 4'b1000, 3, 1));
        tbl0.push_back(mk(4'b1001, 4'b0000, 1, 1, 0, 4'b0000, 0, 1));
        tbl0.push_back(mk(4'b1001, 4'b0001, 1, 0, 1, 4'b0001, 0, 0));
        tbl0.push_back(mk(4'b0000, 4'b0000, 1, 0, 0, 4'b0000, 0, 0));
        tbl0.push_back(mk(4'b1001, 4'b1001, 0, 0, 1, 4'b0000, 3, 0));
        tbl0.push_back(mk(4'b1001, 4'b1001, 1, 0, 1, 4'b1000, 3, 0));

        // Quantum of two: each source keeps the grant for two single-beat packets.
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0001, 0, 0));
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0001, 0, 0));
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0010, 1, 0));
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0010, 1, 0));
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0001, 0, 0));
        tbl1.push_back(mk(4'b0011, 4'b0011, 1, 0, 1, 4'b0001, 0, 0));

        // Reset state, observed while reset is held with every source requesting.
        drive(0, 4'hf, 4'hf, 0, 0, fixed_dat);
        drive(1, 4'hf, 4'hf, 0, 0, fixed_dat);
        @(negedge clk);
        check_outputs(0, "reset0", 1, 4'b0000, 0, 0, fixed_dat, 4'hf);
        check_outputs(1, "reset1", 1, 4'b0000, 0, 0, fixed_dat, 4'hf);
`ifdef RR_PKT_ARB_TIMEOUT_EN
        chk("reset timeout_o", 64'(timeout0), 64'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 4'h0, 4'h0, 0, 0, fixed_dat);
        drive(1, 4'h0, 4'h0, 0, 0, fixed_dat);
        @(posedge clk);
        #1;

        run_table(0, "tbl_q1", tbl0);
        run_table(1, "tbl_q2", tbl1);

`ifdef RR_PKT_ARB_TIMEOUT_EN
        drive(0, 4'b0000, 4'b0000, 1, 1, fixed_dat);
        @(posedge clk); #1;
        drive(0, 4'b0100, 4'b0000, 1, 0, fixed_dat);
        @(negedge clk);
        check_outputs(0, "to_lock", 1, 4'b0100, 2, 0, fixed_dat, 4'b0000);
        @(posedge clk); #1;
        for (int c = 1; c <= 4; c++) begin
            drive(0, 4'b1000, 4'b1000, 1, 0, fixed_dat);
            @(negedge clk);
            check_outputs(0, $sformatf("to_wait%0d", c), 0, 4'b0000, 0, 1, fixed_dat, 4'b1000);
            chk($sformatf("to_wait%0d timeout_o", c), 64'(timeout0), 64'(0));
            $display("timeout wait cycle %0d", c);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_pulse timeout_o", 64'(timeout0), 64'(1));
        check_outputs(0, "to_after", 1, 4'b1000, 3, 0, fixed_dat, 4'b1000);
        @(posedge clk); #1;
        drive(0, 4'b0000, 4'b0000, 1, 0, fixed_dat);
        @(negedge clk);
        chk("to_clear timeout_o", 64'(timeout0), 64'(0));
        chk("q2 timeout_o", 64'(timeout1), 64'(0));
        @(posedge clk); #1;
`endif

        // Random packet traffic on both instances from a fresh reset.
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            for (int k = 0; k < N; k++) begin
                rem[d][k] = 0;
                sdat[d][k] = '0;
            end
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < N; k++) begin
                    if (rem[d][k] == 0 && ($urandom % 3) == 0) begin
                        rem[d][k] = int'($urandom_range(1, 4));
                        sdat[d][k] = $urandom;
                    end
                    rv[d][k] = (rem[d][k] > 0);
                    rl[d][k] = (rem[d][k] == 1);
                    rdat[d][k] = sdat[d][k];
                end
                rrdy[d] = (($urandom % 4) != 0);
                rfl[d] = (($urandom % 50) == 0);
                drive(d, rv[d], rl[d], rrdy[d], rfl[d], rdat[d]);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                logic hit;
                rev[d] = 1'b0; rer[d] = 4'b0000; rei[d] = 0; hit = 1'b0;
                if (m_locked[d] != 0) begin
                    rei[d] = m_lock[d];
                    rev[d] = rv[d][m_lock[d]];
                end else begin
                    for (int j = 0; j < N; j++) begin
                        if (!hit && rv[d][(m_top[d] + j) % N]) begin
                            rei[d] = (m_top[d] + j) % N;
                            hit = 1'b1;
                        end
                    end
                    rev[d] = hit;
                end
                if (rfl[d]) rev[d] = 1'b0;
                if (rev[d] && rrdy[d]) rer[d][rei[d]] = 1'b1;
                check_outputs(d, $sformatf("rand%0d c%0d", d, cyc), rev[d], rer[d], rei[d], 1'(m_locked[d]),
                              rdat[d], rl[d]);
                if (rfl[d]) model_reset(d);
                else if (rev[d] && rrdy[d]) begin
                    if (rl[d][rei[d]]) begin
                        m_locked[d] = 0;
                        model_pkt_end(d, rei[d]);
                    end else begin
                        m_locked[d] = 1;
                        m_lock[d] = rei[d];
                    end
                end
                for (int k = 0; k < N; k++) begin
                    if (rer[d][k]) begin
                        rem[d][k]--;
                        sdat[d][k] = $urandom;
                    end
                end
            end
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
